// File: rtl/motion_door_timer_pkg.sv
// motion_door_timer_pkg
//   Shared definitions for the door/motion timer: FSM phase encodings
//   (these are also the debug value driven on the 'phase' port), door
//   position encodings and the default tick counts at the 32 Hz clock.
package motion_door_timer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'b000,
        PH_OPENING   = 3'b001,
        PH_HOLD      = 3'b010,
        PH_CLOSING   = 3'b011,
        PH_RUN       = 3'b100,
        PH_WAIT_DROP = 3'b101
    } phase_e;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'b00,
        DOOR_OPENING = 2'b01,
        DOOR_OPEN    = 2'b10,
        DOOR_CLOSING = 2'b11
    } door_pos_e;

    localparam int DEF_TRAVEL_TICKS = 32;  // door fully open or fully closed
    localparam int DEF_HOLD_TICKS   = 96;  // door dwell while fully open
    localparam int DEF_RUN_TICKS    = 64;  // one floor of travel
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/motion_door_timer_tick_downcounter.sv
// motion_door_timer_tick_downcounter
//   Loadable down-counter that times each door/motion phase. It saturates
//   at zero, so a decrement request while already at zero is harmless.
//
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   load load_val this cycle
//   load_val  in   value to load (CNT_W bits)
//   dec       in   decrement by one unless already zero
//   count     out  current count
//   zero      out  count == 0
module motion_door_timer_tick_downcounter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    // NOTE: clocked state is always assigned with <= so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/motion_door_timer.sv
// motion_door_timer
//   Responder side of the car-controller handshake. Times door cycles
//   (open, hold, close, with obstruction reversal and hold/close buttons)
//   and one-floor moves, and answers each with a one-cycle completion pulse.
//   The served request must then be dropped before a new one is accepted.
//
//   clk         in   32 Hz system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   switch      in   master switch; 0 forces idle synchronously
//   opendoor    in   door-cycle request level
//   mv2nxt      in   one-floor move request level
//   door_hold   in   open button, restarts the hold time
//   door_close  in   close button, ends the hold early
//   obstruct    in   door-edge sensor, reverses a closing door
//   endOpen     out  one-cycle pulse: door cycle done, door closed
//   endRun      out  one-cycle pulse: move done
//   door_pos    out  00 closed, 01 opening, 10 open, 11 closing
//   running     out  car in motion
//   phase       out  FSM state encoding (debug)
module motion_door_timer
    import motion_door_timer_pkg::*;
#(
    parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int RUN_TICKS    = DEF_RUN_TICKS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic       opendoor,
    input  logic       mv2nxt,
    input  logic       door_hold,
    input  logic       door_close,
    input  logic       obstruct,
    output logic       endOpen,
    output logic       endRun,
    output logic [1:0] door_pos,
    output logic       running,
    output logic [2:0] phase
);

    // Counter reload values: a phase of N ticks loads N-1.
    localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RUN_LD    = CNT_W'(RUN_TICKS - 1);

    phase_e           state;
    door_pos_e        door_q;
    logic             served_run;   // which request WAIT_DROP waits on
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_ld_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign phase    = state;
    assign door_pos = door_q;

    motion_door_timer_tick_downcounter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Counter control, mirroring the transitions taken in the FSM below.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        cnt_clr    = !switch;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = '0;
        if (switch) begin
            unique case (state)
                PH_IDLE: begin
                    if (opendoor) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = TRAVEL_LD;
                    end else if (mv2nxt) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = RUN_LD;
                    end
                end
                PH_OPENING: begin
                    if (cnt_zero) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = HOLD_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (door_hold) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = HOLD_LD;
                    end else if (door_close || cnt_zero) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = TRAVEL_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PH_CLOSING: begin
                    // Reopen only as far as the door has already closed.
                    if (obstruct) begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = TRAVEL_LD - cnt;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PH_RUN: begin
                    cnt_dec = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PH_IDLE;
            door_q     <= DOOR_CLOSED;
            served_run <= 1'b0;
            endOpen    <= 1'b0;
            endRun     <= 1'b0;
            running    <= 1'b0;
        end else if (!switch) begin
            state      <= PH_IDLE;
            door_q     <= DOOR_CLOSED;
            served_run <= 1'b0;
            endOpen    <= 1'b0;
            endRun     <= 1'b0;
            running    <= 1'b0;
        end else begin
            endOpen <= 1'b0;
            endRun  <= 1'b0;
            unique case (state)
                PH_IDLE: begin
                    // Door request wins: the car only moves with the door shut.
                    if (opendoor) begin
                        state  <= PH_OPENING;
                        door_q <= DOOR_OPENING;
                    end else if (mv2nxt) begin
                        state   <= PH_RUN;
                        running <= 1'b1;
                    end
                end
                PH_OPENING: begin
                    if (cnt_zero) begin
                        state  <= PH_HOLD;
                        door_q <= DOOR_OPEN;
                    end
                end
                PH_HOLD: begin
                    if (!door_hold && (door_close || cnt_zero)) begin
                        state  <= PH_CLOSING;
                        door_q <= DOOR_CLOSING;
                    end
                end
                PH_CLOSING: begin
                    if (obstruct) begin
                        state  <= PH_OPENING;
                        door_q <= DOOR_OPENING;
                    end else if (cnt_zero) begin
                        state      <= PH_WAIT_DROP;
                        door_q     <= DOOR_CLOSED;
                        served_run <= 1'b0;
                        endOpen    <= 1'b1;
                    end
                end
                PH_RUN: begin
                    if (cnt_zero) begin
                        state      <= PH_WAIT_DROP;
                        running    <= 1'b0;
                        served_run <= 1'b1;
                        endRun     <= 1'b1;
                    end
                end
                PH_WAIT_DROP: begin
                    // Hold off until the served request is withdrawn so the
                    // controller cannot see a second completion pulse.
                    if (served_run ? !mv2nxt : !opendoor) begin
                        state <= PH_IDLE;
                    end
                end
                default: begin
                    state <= PH_IDLE;
                end
            endcase
        end
    end

endmodule
